// File: rtl/axis_skew_feed.sv
// AXIS front end for the systolic skew stage: 2-entry registered skid buffer
// feeding the shared advance enable, with N zero beats appended per packet.
//
// state  | meaning
// STREAM | issue buffered beats whenever the array advances
// FLUSH  | inject zero beats until the skew triangle has drained
module axis_skew_feed #(
  parameter int R  = 4,
  parameter int W  = 8,
  parameter int N  = 3,
  parameter int WC = 16
) (
  input  logic          c,
  input  logic          rg,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [R*W-1:0] s_data,
  input  logic          s_last,
  input  logic          m_ready,
  output logic          e,
  output logic [R*W-1:0] d,
  output logic          v,
  output logic          flush,
  output logic          done,
  output logic [WC-1:0] beats
);

  localparam int FW = $clog2(N + 2);

  typedef enum logic {STREAM, FLUSH} state_t;

  state_t         state, state_nxt;
  logic [FW-1:0]  fcnt, fcnt_nxt;
  logic [R*W-1:0] buf_d [2];
  logic           buf_l [2];
  logic           rd_ptr, wr_ptr;
  logic [1:0]     cnt, cnt_nxt;
  logic           push, pop, fin;
  logic [R*W-1:0] head_d;
  logic           head_l;

  assign push   = s_valid && s_ready;
  assign head_d = buf_d[rd_ptr];
  assign head_l = buf_l[rd_ptr];

  always_comb begin
    cnt_nxt = cnt;
    case ({push, pop})
      2'b10:   cnt_nxt = cnt + 2'd1;
      2'b01:   cnt_nxt = cnt - 2'd1;
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge c or posedge rg) begin
    if (rg) begin
      state <= STREAM;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  // The last data beat either opens the drain window or, with N=0, closes the packet.
  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    fin       = 1'b0;
    pop       = 1'b0;
    e         = 1'b0;
    v         = 1'b0;
    flush     = 1'b0;
    case (state)
      STREAM: begin
        if (m_ready && cnt != 2'd0) begin
          e   = 1'b1;
          v   = 1'b1;
          pop = 1'b1;
          if (head_l) begin
            if (N > 0) begin
              state_nxt = FLUSH;
              fcnt_nxt  = FW'(N);
            end else begin
              fin = 1'b1;
            end
          end
        end
      end
      FLUSH: begin
        flush = 1'b1;
        if (m_ready) begin
          e        = 1'b1;
          fcnt_nxt = fcnt - FW'(1);
          if (fcnt == FW'(1)) begin
            state_nxt = STREAM;
            fin       = 1'b1;
          end
        end
      end
      default: state_nxt = STREAM;
    endcase
  end

  assign d = v ? head_d : '0;

  always_ff @(posedge c or posedge rg) begin
    if (rg) begin
      buf_d[0] <= '0;
      buf_d[1] <= '0;
      buf_l[0] <= 1'b0;
      buf_l[1] <= 1'b0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      cnt      <= 2'd0;
      s_ready  <= 1'b0;
      done     <= 1'b0;
      beats    <= '0;
    end else begin
      if (push) begin
        buf_d[wr_ptr] <= s_data;
        buf_l[wr_ptr] <= s_last;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt     <= cnt_nxt;
      s_ready <= (cnt_nxt < 2'd2);
      done    <= fin;
      if (fin)
        beats <= '0;
      else if (pop && beats != '1)
        beats <= beats + WC'(1);
    end
  end

endmodule
